// File: rtl/ahb_apb_pkg.sv
// Shared encodings and state type for the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

  // AHB htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB hresp encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SETUP,
    ACCESS,
    OK,
    ERR1,
    ERR2
  } bridge_state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-strobe generator: maps AHB hsize/haddr[1:0] to APB4 pstrb and flags illegal sizes.
module apb_strb_gen (
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  input  logic       i_write,
  output logic [3:0] o_strb,
  output logic       o_illegal
);

  // Decode size into lanes; reads never drive strobes.
  always_comb begin
    o_strb    = 4'b0000;
    o_illegal = 1'b0;
    case (i_hsize)
      3'd0:    o_strb = 4'b0001 << i_addr_lo;
      3'd1:    o_strb = 4'b0011 << {i_addr_lo[1], 1'b0};
      3'd2:    o_strb = 4'b1111;
      default: o_illegal = 1'b1;
    endcase
    if (!i_write) begin
      o_strb = 4'b0000;
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave that turns one AHB transfer at a time into an APB4 SETUP/ACCESS sequence.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_W-1:0]     haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_W-1:0]     hwdata,
  output logic                  hready,
  output logic                  hresp,
  output logic [DATA_W-1:0]     hrdata,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  bridge_state_e          r_state;
  bridge_state_e          w_state_next;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_SLAVES-1:0]  r_psel;
  logic                   r_penable;
  logic [ADDR_W-1:0]      r_paddr;
  logic                   r_pwrite;
  logic [DATA_W-1:0]      r_pwdata;
  logic [DATA_W/8-1:0]    r_pstrb;
  logic [DATA_W-1:0]      r_hrdata;
  logic [NUM_SLAVES-1:0]  w_sel_onehot;
  logic [3:0]             w_strb;
  logic                   w_illegal;
  logic                   w_accept;
  logic                   w_timeout;

  apb_strb_gen u_strb_gen (
    .i_hsize   (hsize),
    .i_addr_lo (haddr[1:0]),
    .i_write   (hwrite),
    .o_strb    (w_strb),
    .o_illegal (w_illegal)
  );

  // One-hot select decoded from the latched slave index.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign w_sel_onehot[gi] = (r_idx == IDX_W'(gi));
  end

  // hready doubles as the arbiter's regrant signal, so it is high only between transfers.
  assign hready    = (r_state == IDLE) || (r_state == OK) || (r_state == ERR2);
  assign hresp     = (r_state == ERR1) || (r_state == ERR2);
  assign w_accept  = hsel & htrans_active(htrans) & hready;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign hrdata  = r_hrdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign paddr   = r_paddr;
  assign pwrite  = r_pwrite;
  assign pwdata  = r_pwdata;
  assign pstrb   = r_pstrb;

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; illegal sizes skip the APB access and go straight to the error response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, OK, ERR2: begin
        if (w_accept) w_state_next = w_illegal ? ERR1 : CAPTURE;
        else          w_state_next = IDLE;
      end
      CAPTURE: w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS: begin
        if (pready)         w_state_next = pslverr ? ERR1 : OK;
        else if (w_timeout) w_state_next = ERR1;
      end
      ERR1:    w_state_next = ERR2;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered APB outputs, address-phase capture, wait counter and read data.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_hrdata  <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= haddr;
        r_pwrite <= hwrite;
        r_idx    <= haddr[SEL_LSB +: IDX_W];
        r_pstrb  <= w_strb;
      end
      if (r_state == CAPTURE) begin
        r_pwdata <= hwdata;
      end
      if ((r_state == ACCESS) && pready && !pslverr && !r_pwrite) begin
        r_hrdata <= prdata;
      end
      r_cnt     <= ((r_state == ACCESS) && (w_state_next == ACCESS)) ? r_cnt + 1'b1 : '0;
      r_psel    <= ((w_state_next == SETUP) || (w_state_next == ACCESS)) ? w_sel_onehot : '0;
      r_penable <= (w_state_next == ACCESS);
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: scoreboard of expected AHB completions plus inline APB checks.
module tb_ahb2apb_bridge;

  localparam int TIMEOUT = 16;
  localparam int LIMIT   = TIMEOUT + 20;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    logic        rd;
    int          lat;
    int          err1;
    int          acc;
    logic        sel;
  } exp_t;

  exp_t sb[$];

  ahb2apb_bridge #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(TIMEOUT)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [2:0] sz, input logic [1:0] lo);
    case ({sz, lo})
      5'b000_00: return 4'b0001;
      5'b000_01: return 4'b0010;
      5'b000_10: return 4'b0100;
      5'b000_11: return 4'b1000;
      5'b001_00, 5'b001_01: return 4'b0011;
      5'b001_10, 5'b001_11: return 4'b1100;
      5'b010_00, 5'b010_01, 5'b010_10, 5'b010_11: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic idle(input int n);
    hsel   = 1'b0;
    htrans = 2'b00;
    repeat (n) @(negedge hclk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hready"},  hready,  1);
    chk({tag, "_hresp"},   hresp,   0);
    chk({tag, "_hrdata"},  hrdata,  0);
    chk({tag, "_psel"},    psel,    0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_paddr"},   paddr,   0);
    chk({tag, "_pwrite"},  pwrite,  0);
    chk({tag, "_pwdata"},  pwdata,  0);
    chk({tag, "_pstrb"},   pstrb,   0);
  endtask

  // Called at a negedge where hready is expected high; that cycle is the address phase.
  // waits < 0 means the slave never answers.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd, input int waits,
                      input logic serr);
    exp_t        e;
    exp_t        got_e;
    int          c;
    int          acc;
    int          c_err1;
    logic        seen_sel;
    logic        bad_stable;
    logic        illegal;
    logic [3:0]  es;
    logic [3:0]  esel;
    illegal    = (sz > 3'd2);
    es         = wr ? model_strb(sz, addr[1:0]) : 4'b0000;
    esel       = 4'b0001 << addr[13:12];
    chk("accept_hready", hready, 1);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = sz;
    e.resp  = illegal || serr || (waits < 0);
    e.rdata = rd;
    e.rd    = !wr && !e.resp;
    e.sel   = !illegal;
    if (illegal)        begin e.lat = 2;                 e.acc = 0;         end
    else if (waits < 0) begin e.lat = 4 + TIMEOUT;       e.acc = TIMEOUT;   end
    else                begin e.lat = 4 + waits + serr;  e.acc = waits + 1; end
    e.err1 = e.resp ? e.lat - 1 : -1;
    sb.push_back(e);
    c = 0; acc = 0; c_err1 = -1; seen_sel = 1'b0; bad_stable = 1'b0;
    while (1) begin
      @(negedge hclk);
      c++;
      if (c == 1) begin
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
      end
      if (psel != 4'b0000 && !seen_sel) begin
        seen_sel = 1'b1;
        chk("setup_psel",    psel,    esel);
        chk("setup_penable", penable, 0);
        chk("setup_paddr",   paddr,   addr);
        chk("setup_pwrite",  pwrite,  wr);
        chk("setup_pstrb",   pstrb,   es);
        if (wr) chk("setup_pwdata", pwdata, wd);
      end
      if (penable) begin
        acc++;
        if (paddr !== addr || pstrb !== es || psel !== esel || pwrite !== wr) bad_stable = 1'b1;
        pready  = (waits >= 0) && (acc - 1 == waits);
        pslverr = serr && pready;
        prdata  = pready ? rd : 32'hBAD0_BAD0;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hBAD0_BAD0;
      end
      if (hresp && !hready && c_err1 < 0) begin
        c_err1 = c;
        chk("err1_psel",    psel,    0);
        chk("err1_penable", penable, 0);
      end
      if (hready || c >= LIMIT) break;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      got_e = sb.pop_front();
      chk("latency",     c,          got_e.lat);
      chk("hresp",       hresp,      got_e.resp);
      chk("err1_cycle",  c_err1,     got_e.err1);
      chk("access_cnt",  acc,        got_e.acc);
      chk("psel_seen",   seen_sel,   got_e.sel);
      chk("apb_stable",  bad_stable, 0);
      if (got_e.rd) chk("hrdata", hrdata, got_e.rdata);
    end
    $display("xfer addr=%08h wr=%0d size=%0d waits=%0d serr=%0d -> cycles=%0d hresp=%0d hrdata=%08h",
             addr, wr, sz, waits, serr, c, hresp, hrdata);
  endtask

  initial begin
    int k;
    hresetn = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge hclk);
    check_reset_values("reset");
    hresetn = 1'b1;
    @(negedge hclk);

    // IDLE and BUSY with hsel high: zero-wait OKAY, no APB activity
    hsel = 1'b1; htrans = 2'b00;
    @(negedge hclk);
    chk("idle_hready", hready, 1); chk("idle_hresp", hresp, 0); chk("idle_psel", psel, 0);
    htrans = 2'b01;
    @(negedge hclk);
    chk("busy_hready", hready, 1); chk("busy_hresp", hresp, 0); chk("busy_psel", psel, 0);
    $display("xfer htrans IDLE/BUSY -> hready=%0d psel=%0h", hready, psel);
    idle(1);

    xfer(32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    idle(1);
    xfer(32'h0000_3000, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 3, 1'b0);
    xfer(32'h0000_2003, 1'b1, 3'd0, 32'hAA00_0000, 32'h0, 0, 1'b0);
    xfer(32'h0000_2002, 1'b1, 3'd1, 32'h5555_0000, 32'h0, 1, 1'b0);
    idle(1);
    xfer(32'h0000_1000, 1'b1, 3'd3, 32'h1111_2222, 32'h0, 0, 1'b0);
    xfer(32'h0000_1000, 1'b0, 3'd2, 32'h0, 32'hCAFE_0000, 1, 1'b1);
    idle(1);
    chk("post_err_hready", hready, 1); chk("post_err_hresp", hresp, 0);
    xfer(32'h0000_2000, 1'b0, 3'd2, 32'h0, 32'h0, -1, 1'b0);
    idle(1);

    // Back-to-back: the read's address phase lands in the write's OK cycle
    xfer(32'h0000_1008, 1'b1, 3'd2, 32'h0BAD_F00D, 32'h0, 0, 1'b0);
    xfer(32'h0000_2010, 1'b0, 3'd2, 32'h0, 32'h8765_4321, 0, 1'b0);
    idle(1);

    // Reset pulsed in the middle of an ACCESS phase
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_3004; hwrite = 1'b1; hsize = 3'd2;
    @(negedge hclk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h7777_7777;
    k = 0;
    while (!penable && k < LIMIT) begin
      @(negedge hclk);
      k++;
    end
    chk("rst_reach_access", penable, 1);
    hresetn = 1'b0;
    #1;
    check_reset_values("midrst");
    $display("xfer reset during ACCESS -> hready=%0d psel=%0h penable=%0d", hready, psel, penable);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    xfer(32'h0000_0010, 1'b0, 3'd2, 32'h0, 32'h0F0F_0F0F, 2, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

AHB-Lite slave that converts one AHB transfer at a time into an APB4 SETUP/ACCESS sequence on up to NUM_SLAVES peripherals. Sits directly downstream of the AHB arbiter and master multiplexer. Its hready output is the ready signal the arbiter samples before regranting, so bus ownership changes only between transfers. All APB outputs are registered.

## Interface
- ADDR_W, 32: AHB/APB address width.
- DATA_W, 32: data width; fixed at 32 in this revision (4 byte lanes).
- NUM_SLAVES, 4: APB peripheral count; power of two, ≥2.
- SEL_LSB, 12: LSB of slave-index field; index = haddr[SEL_LSB +: $clog2(NUM_SLAVES)].
- TIMEOUT, 16: max ACCESS cycles without pready before abort; ≥2.

Ports:
- hclk  in  1  AHB/APB clock.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  bridge selected (from address decoder).
- haddr  in  ADDR_W  AHB address (address phase).
- htrans  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hwdata  in  DATA_W  write data (data phase).
- hready  out  1  transfer done; also feeds arbiter.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_W  read data, valid when hready=1 after a read.
- psel  out  NUM_SLAVES  one-hot APB select.
- penable  out  1  APB ACCESS phase.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB4 byte strobes.
- prdata  in  DATA_W  read data, pre-muxed from the selected slave.
- pready  in  1  slave ready.
- pslverr  in  1  slave error, sampled with pready.

## Operation
- Reset values: hready=1, hresp=0, hrdata=0, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, pstrb=0, state=IDLE, timeout counter=0.
- A transfer is accepted when hsel & htrans[1] & hready are high at a rising edge. At that edge, haddr, hwrite, the slave index and pstrb are latched.
- pstrb for writes: hsize=0 gives 1<<haddr[1:0]; hsize=1 gives 4'b0011<<{haddr[1],1'b0}; hsize=2 gives 4'b1111. Reads use pstrb=0.
- hsize>2 is illegal. The bridge issues no APB access and goes directly to ERR1.
- FSM states:
  - IDLE: hready=1, hresp=0. On accept, go to CAPTURE.
  - CAPTURE: hready=0. pwdata is latched from hwdata. Go to SETUP.
  - SETUP: psel[idx]=1, penable=0. Go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1, counter increments. On pready&~pslverr, go to OK (hrdata latched on reads). On pready&pslverr, go to ERR1. If counter reaches TIMEOUT-1 without pready, go to ERR1.
  - OK: hready=1, hresp=0, psel=0, penable=0. On accept, go to CAPTURE; otherwise go to IDLE.
  - ERR1: hready=0, hresp=1, psel=0.
  - ERR2: hready=1, hresp=1. On accept, go to CAPTURE; otherwise go to IDLE.
- Unaligned halfword or word addresses are passed to APB unmodified; strobes follow the rule above.
- htrans IDLE or BUSY with hsel=1 gets a zero-wait OKAY and causes no APB activity.

## Timing
- Address phase is cycle N. Then: CAPTURE at N+1, SETUP at N+2, ACCESS at N+3.
- With pready=1 in the first ACCESS cycle, hready=1 and hrdata are valid in N+4. Minimum transfer is 5 cycles, address phase to completion.
- Each pready=0 cycle in ACCESS adds one cycle.
- A timeout produces ERR1 at N+3+TIMEOUT.
- The error response is always two cycles: hready=0/hresp=1, then hready=1/hresp=1.
- Back-to-back transfers: a new accept in OK or ERR2 enters CAPTURE on the next cycle, with no IDLE cycle in between.
- paddr, pwrite and pstrb are stable from SETUP through the last ACCESS cycle.
- Reset asserted mid-transfer forces all reset values immediately (asynchronous). The APB access is dropped with no completion.

## Structure
- Package ahb_apb_pkg holds:
  - htrans encodings (IDLE/BUSY/NONSEQ/SEQ);
  - hresp encodings (OKAY/ERROR);
  - the bridge_state_e enum (IDLE, CAPTURE, SETUP, ACCESS, OK, ERR1, ERR2).
- Sub-module apb_strb_gen: combinational hsize/haddr[1:0]/hwrite → pstrb, plus the illegal-size flag.

## Test plan
- Single write: haddr=0x1004, hsize=2, hwdata=0xDEADBEEF, pready=1. Expect psel=4'b0010, pstrb=4'hF, pwdata=0xDEADBEEF in SETUP and ACCESS, and hready=1/hresp=0 at N+4.
- Read with 3 wait states: haddr=0x3000, prdata=0x12345678. Expect penable high for 4 cycles, hrdata=0x12345678 and hready=1 at N+7.
- Byte write at haddr=0x2003 gives pstrb=4'b1000. Halfword write at 0x2002 gives 4'b1100. hsize=3 gives ERR1/ERR2 with psel never asserted.
- pslverr=1 with pready: expect hready=0/hresp=1, then hready=1/hresp=1, then IDLE.
- pready held 0: expect ERR1 exactly TIMEOUT ACCESS cycles after the first ACCESS cycle, and psel deasserted.
- Back-to-back write then read, plus hresetn pulsed during ACCESS: expect CAPTURE immediately after OK with no IDLE cycle, and all outputs at reset values within the reset cycle.
